// File: rtl/snake_grid_engine.sv
// snake_grid_engine
//   Snake game engine that draws directly into a character-cell text RAM.
//   The body is tracked in a circular buffer of cell addresses (head
//   pointer, tail pointer, length counter). The text RAM is read only to
//   classify the cell the head is about to enter, or a candidate fruit cell.
//
// Build option:
//   SNAKE_WRAP_EN  defined   : leaving an edge wraps to the opposite edge.
//                  undefined : leaving an edge ends the game (no head write).
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   tick         single-cycle step strobe (honoured only in WAIT)
//   keypad[3:0]  bit0 left, bit1 right, bit2 down, bit3 up (level)
//   random       free-running pseudo-random cell index (fruit placement)
//   vga_rd       text-RAM read data, valid one cycle after vga_addr
//   vga_addr     cell address, row*COLS+col
//   vga_we       one-cycle write strobe per cell write
//   vga_data     16'h0000 empty, 16'h0a00 body, 16'h0500 fruit
//   game_over    high from a collision until reset
//   score        fruits eaten, saturating
//   o_dbg_state  current FSM state (debug visibility)
//
// Text-RAM handshake: the engine presents an address on vga_addr (registered);
// the RAM answers on vga_rd one cycle later, so every read spends one
// address cycle and one evaluate cycle. A write is vga_we high for exactly
// one cycle with vga_addr/vga_data stable in that cycle.
module snake_grid_engine #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [3:0]        keypad,
    input  logic [ADDR_W-1:0] random,
    input  logic [15:0]       vga_rd,
    output logic [ADDR_W-1:0] vga_addr,
    output logic              vga_we,
    output logic [15:0]       vga_data,
    output logic              game_over,
    output logic [15:0]       score,
    output logic [3:0]        o_dbg_state
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int LW    = PW + 1;
    localparam int NCELL = COLS * ROWS;
    localparam int PCW   = $clog2(NCELL) + 1;

    localparam logic [CW-1:0]     LAST_COL   = CW'(COLS - 1);
    localparam logic [RW-1:0]     LAST_ROW   = RW'(ROWS - 1);
    localparam logic [RW-1:0]     INIT_ROW   = RW'(ROWS / 2);
    localparam logic [ADDR_W-1:0] INIT_BASE  = ADDR_W'((ROWS / 2) * COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(NCELL - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ROW_SPAN   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COL_SPAN   = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [PCW-1:0]    PROBE_LAST = PCW'(NCELL - 1);
    localparam logic [LW-1:0]     MAX_LEN_L  = LW'(MAX_LEN);
    localparam logic [LW-1:0]     INIT_LEN_L = LW'(INIT_LEN);

    localparam logic [15:0] CELL_EMPTY = 16'h0000;
    localparam logic [15:0] CELL_BODY  = 16'h0a00;
    localparam logic [15:0] CELL_FRUIT = 16'h0500;

    // Direction encoding chosen so that the opposite direction is dir ^ 1.
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

`ifdef SNAKE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_PLACE  = 4'd1,
        S_PROBE  = 4'd2,
        S_WAIT   = 4'd3,
        S_STEP   = 4'd4,
        S_READ   = 4'd5,
        S_DECIDE = 4'd6,
        S_ERASE  = 4'd7,
        S_OVER   = 4'd8
    } state_t;

    state_t            r_state;
    logic              r_vga_we;
    logic [ADDR_W-1:0] r_vga_addr;
    logic [15:0]       r_vga_data;
    logic              r_game_over;
    logic [15:0]       r_score;
    logic [LW-1:0]     r_len;
    logic [1:0]        r_dir;
    logic [1:0]        r_pend;
    logic [PW-1:0]     r_init_cnt;
    logic [PW-1:0]     r_head_ptr;
    logic [PW-1:0]     r_tail_ptr;
    logic [PCW-1:0]    r_probe_cnt;
    logic              r_probe_ph;
    logic              r_erase_to_place;
    logic [ADDR_W-1:0] r_erase_addr;
    logic [CW-1:0]     r_head_col;
    logic [RW-1:0]     r_head_row;
    logic [ADDR_W-1:0] r_head_addr;
    logic [ADDR_W-1:0] r_buf [MAX_LEN];

    logic [CW-1:0]     w_nxt_col;
    logic [RW-1:0]     w_nxt_row;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic              w_edge_hit;
    logic              w_key_valid;
    logic [1:0]        w_key_dir;
    logic [1:0]        w_applied;
    logic              w_key_ok;
    logic [ADDR_W-1:0] w_init_addr;
    logic [PW-1:0]     w_head_ptr_nxt;

    assign w_init_addr    = INIT_BASE + ADDR_W'(r_init_cnt);
    assign w_head_ptr_nxt = r_head_ptr + PW'(1);

    // Next head cell from column/row counters; the address moves by +-1 or
    // +-COLS, and by a full row/column span when wrapping.
    always_comb begin
        w_nxt_col  = r_head_col;
        w_nxt_row  = r_head_row;
        w_nxt_addr = r_head_addr;
        w_edge_hit = 1'b0;
        case (r_dir)
            DIR_LEFT: begin
                if (r_head_col == '0) begin
                    w_edge_hit = 1'b1;
                    w_nxt_col  = LAST_COL;
                    w_nxt_addr = r_head_addr + ROW_SPAN;
                end else begin
                    w_nxt_col  = r_head_col - CW'(1);
                    w_nxt_addr = r_head_addr - ADDR_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (r_head_col == LAST_COL) begin
                    w_edge_hit = 1'b1;
                    w_nxt_col  = '0;
                    w_nxt_addr = r_head_addr - ROW_SPAN;
                end else begin
                    w_nxt_col  = r_head_col + CW'(1);
                    w_nxt_addr = r_head_addr + ADDR_W'(1);
                end
            end
            DIR_DOWN: begin
                if (r_head_row == LAST_ROW) begin
                    w_edge_hit = 1'b1;
                    w_nxt_row  = '0;
                    w_nxt_addr = r_head_addr - COL_SPAN;
                end else begin
                    w_nxt_row  = r_head_row + RW'(1);
                    w_nxt_addr = r_head_addr + ROW_STEP;
                end
            end
            default: begin
                if (r_head_row == '0) begin
                    w_edge_hit = 1'b1;
                    w_nxt_row  = LAST_ROW;
                    w_nxt_addr = r_head_addr + COL_SPAN;
                end else begin
                    w_nxt_row  = r_head_row - RW'(1);
                    w_nxt_addr = r_head_addr - ROW_STEP;
                end
            end
        endcase
    end

    // Keypad priority left > right > down > up. Reversal is judged against
    // the direction in effect after this cycle, so a key arriving on the
    // applying tick cannot sneak in a 180-degree turn.
    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = DIR_RIGHT;
        if (keypad[0])      w_key_dir = DIR_LEFT;
        else if (keypad[1]) w_key_dir = DIR_RIGHT;
        else if (keypad[2]) w_key_dir = DIR_DOWN;
        else if (keypad[3]) w_key_dir = DIR_UP;
        else                w_key_valid = 1'b0;
        w_applied = (r_state == S_WAIT && tick) ? r_pend : r_dir;
        w_key_ok  = w_key_valid && (w_key_dir != (w_applied ^ 2'b01));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_INIT;
            r_vga_we         <= 1'b0;
            r_vga_addr       <= '0;
            r_vga_data       <= '0;
            r_game_over      <= 1'b0;
            r_score          <= '0;
            r_len            <= INIT_LEN_L;
            r_dir            <= DIR_RIGHT;
            r_pend           <= DIR_RIGHT;
            r_init_cnt       <= '0;
            r_head_ptr       <= '0;
            r_tail_ptr       <= '0;
            r_probe_cnt      <= '0;
            r_probe_ph       <= 1'b0;
            r_erase_to_place <= 1'b0;
            r_erase_addr     <= '0;
            r_head_col       <= '0;
            r_head_row       <= INIT_ROW;
            r_head_addr      <= INIT_BASE;
        end else begin
            r_vga_we <= 1'b0;
            if (r_state != S_OVER && w_key_ok) begin
                r_pend <= w_key_dir;
            end
            case (r_state)
                S_INIT: begin
                    r_vga_we             <= 1'b1;
                    r_vga_addr           <= w_init_addr;
                    r_vga_data           <= CELL_BODY;
                    r_buf[r_init_cnt]    <= w_init_addr;
                    if (r_init_cnt == PW'(INIT_LEN - 1)) begin
                        r_head_ptr  <= r_init_cnt;
                        r_tail_ptr  <= '0;
                        r_head_col  <= CW'(INIT_LEN - 1);
                        r_head_row  <= INIT_ROW;
                        r_head_addr <= w_init_addr;
                        r_state     <= S_PLACE;
                    end else begin
                        r_init_cnt <= r_init_cnt + PW'(1);
                    end
                end
                S_PLACE: begin
                    r_vga_addr  <= random;
                    r_probe_cnt <= '0;
                    r_probe_ph  <= 1'b0;
                    r_state     <= S_PROBE;
                end
                S_PROBE: begin
                    // Phase 0 lets the RAM answer; phase 1 classifies the cell.
                    if (!r_probe_ph) begin
                        r_probe_ph <= 1'b1;
                    end else if (vga_rd == CELL_EMPTY) begin
                        r_vga_we   <= 1'b1;
                        r_vga_data <= CELL_FRUIT;
                        r_state    <= S_WAIT;
                    end else if (r_probe_cnt == PROBE_LAST) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_vga_addr  <= (r_vga_addr >= LAST_CELL) ? '0 : r_vga_addr + ADDR_W'(1);
                        r_probe_cnt <= r_probe_cnt + PCW'(1);
                        r_probe_ph  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        r_dir   <= r_pend;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (w_edge_hit && !WRAP_EN) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        r_vga_addr <= w_nxt_addr;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_DECIDE;
                end
                S_DECIDE: begin
                    // Head position and direction are unchanged since STEP, so
                    // the next-cell logic still describes the cell being read.
                    if (vga_rd == CELL_EMPTY || vga_rd == CELL_FRUIT) begin
                        r_vga_we              <= 1'b1;
                        r_vga_data            <= CELL_BODY;
                        r_buf[w_head_ptr_nxt] <= w_nxt_addr;
                        r_head_ptr            <= w_head_ptr_nxt;
                        r_head_col            <= w_nxt_col;
                        r_head_row            <= w_nxt_row;
                        r_head_addr           <= w_nxt_addr;
                        // Capture the tail now: at full length the new head
                        // entry lands on the tail slot.
                        r_erase_addr          <= r_buf[r_tail_ptr];
                        if (vga_rd == CELL_FRUIT) begin
                            if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                            if (r_len != MAX_LEN_L) begin
                                r_len   <= r_len + LW'(1);
                                r_state <= S_PLACE;
                            end else begin
                                r_erase_to_place <= 1'b1;
                                r_state          <= S_ERASE;
                            end
                        end else begin
                            r_erase_to_place <= 1'b0;
                            r_state          <= S_ERASE;
                        end
                    end else begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end
                end
                S_ERASE: begin
                    r_vga_we   <= 1'b1;
                    r_vga_addr <= r_erase_addr;
                    r_vga_data <= CELL_EMPTY;
                    r_tail_ptr <= r_tail_ptr + PW'(1);
                    r_state    <= r_erase_to_place ? S_PLACE : S_WAIT;
                end
                S_OVER: begin
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign vga_addr    = r_vga_addr;
    assign vga_we      = r_vga_we;
    assign vga_data    = r_vga_data;
    assign game_over   = r_game_over;
    assign score       = r_score;
    assign o_dbg_state = r_state;

endmodule

// File: doc/snake_grid_engine.md
SNAKE_GRID_ENGINE -- requirements
Module: snake_grid_engine

Interface
REQ-001 Parameter COLS, default 80: text grid columns.
REQ-002 Parameter ROWS, default 30: text grid rows.
REQ-003 Parameter MAX_LEN, default 64: body buffer depth in segments, power of two, at least 8.
REQ-004 Parameter INIT_LEN, default 4: segment count after reset, 2..MAX_LEN.
REQ-005 Parameter ADDR_W, default 12: cell address width; COLS*ROWS SHALL fit in ADDR_W bits.
REQ-006 Port clk, input, 1: clock; reset rst, synchronous, active-high; clock clk.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port tick, input, 1: single-cycle step strobe from the timer.
REQ-009 Port keypad, input, 4: bit0 left, bit1 right, bit2 down, bit3 up; level-sensitive.
REQ-010 Port random, input, ADDR_W: free-running pseudo-random cell index.
REQ-011 Port vga_rd, input, 16: text-RAM read data, valid one cycle after vga_addr.
REQ-012 Port vga_addr, output, ADDR_W: cell address, row*COLS+col.
REQ-013 Port vga_we, output, 1: write strobe for vga_data at vga_addr.
REQ-014 Port vga_data, output, 16: 16'h0000 empty, 16'h0a00 body, 16'h0500 fruit.
REQ-015 Port game_over, output, 1: high from collision until reset.
REQ-016 Port score, output, 16: fruits eaten, saturating at 16'hFFFF.

Function
REQ-017 Body positions SHALL be held in a MAX_LEN-entry circular buffer with head pointer, tail pointer and length counter; vga_rd is not used to locate the tail.
REQ-018 FSM states: INIT, PLACE, PROBE, WAIT, STEP, READ, DECIDE, ERASE, OVER.
REQ-019 INIT SHALL write INIT_LEN body cells, one per cycle, on row ROWS/2 at columns 0..INIT_LEN-1, with the head at column INIT_LEN-1 and direction right; then go to PLACE.
REQ-020 PLACE/PROBE SHALL read cell random; if empty, write fruit and go to WAIT; otherwise advance the address by 1, wrapping at COLS*ROWS to 0. After COLS*ROWS failed probes, go to WAIT with no fruit.
REQ-021 A pending direction SHALL be latched from keypad in any state; priority left>right>down>up; a request opposite to the direction last applied SHALL be ignored.
REQ-022 WAIT: on tick, go to STEP and apply the pending direction.
REQ-023 STEP SHALL compute the next head cell using column and row counters, not division.
REQ-024 READ/DECIDE: empty cell -> write head, go to ERASE; fruit cell -> write head, score+1, length+1 (no tail erase), go to PLACE; any other value -> OVER.
REQ-025 At length MAX_LEN, eating fruit SHALL increment score, keep the length, erase the tail, then go to PLACE.
REQ-026 ERASE SHALL write 16'h0000 at the tail, advance the tail pointer, and go to WAIT.
REQ-027 Moving into the current tail cell SHALL count as a collision.
REQ-028 OVER SHALL hold game_over=1 and vga_we=0, ignore tick and keypad, and stay until rst.
REQ-029 A tick that arrives outside WAIT SHALL be dropped, not queued.
REQ-030 vga_we SHALL be high for exactly one cycle per cell write.

Reset
REQ-031 rst SHALL, from any state and with priority over tick, set: state INIT, vga_we=0, vga_addr=0, vga_data=0, game_over=0, score=0, length=INIT_LEN, direction right.
REQ-032 rst SHALL NOT clear the text RAM; INIT overwrites only the initial segments.

Configuration
REQ-033 Macro SNAKE_WRAP_EN defined: leaving any edge SHALL wrap to the opposite edge on the same row or column.
REQ-034 Macro SNAKE_WRAP_EN undefined: leaving any edge SHALL enter OVER with no head write.

Verification
REQ-035 Scenario: reset, empty RAM, 2 ticks, no keys -> head at cell 15*80+5; cells 1200 and 1201 are 0; score=0.
REQ-036 Scenario: fruit placed at head+1, one tick -> score=1, length 5, no tail erase, a new fruit is written.
REQ-037 Scenario: keypad=left while moving right, then tick -> direction unchanged, head advances right.
REQ-038 Scenario: head at column 79 moving right, tick -> with SNAKE_WRAP_EN the head lands at column 0 of the same row; without it game_over=1 and no write occurs.
REQ-039 Scenario: body arranged so that down, left, up hits a segment -> game_over=1 after the third tick; later ticks cause no writes.
REQ-040 Scenario: rst asserted during PROBE -> next cycle state INIT, vga_we=0, score=0.
